// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the fp16 divider and multiplier.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS = 15;
  localparam logic [14:0] MAX_FINITE = 15'h7BFF;
  localparam int QBITS = 12;
  localparam int DENORM_CAP = 13;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ALIGN,
    ITER,
    DENORM,
    ROUND,
    DONE
  } state_e;

  // Zero test on the magnitude only, so -0 counts as zero
  function automatic logic is_zero(input logic [15:0] v);
    return v[14:0] == 15'h0000;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Combinational leading-zero counter over an 11-bit significand.
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [MAN_W:0] din_i,
  output logic [3:0]     count_o
);

  // Scan LSB to MSB so the highest set bit decides the final count
  always_comb begin
    count_o = 4'd11;
    for (int i = 0; i <= MAN_W; i++) begin
      if (din_i[i]) count_o = 4'(MAN_W - i);
    end
  end

endmodule

// File: rtl/div_float16.sv
// Sequential binary16 divider: restoring radix-2 mantissa division with
// round-to-nearest-even. Saturates instead of producing Inf/NaN.
module div_float16
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic        data_valid,
  output logic [15:0] result,
  output logic        complete,
  output logic        busy
);

  state_e                         state_q;
  logic [15:0]                    a_q, b_q;
  logic                           sign_q, a_zero_q, b_zero_q, sticky_q;
  logic signed [7:0]              e_q;
  logic [QBITS-1:0]               rem_q, quo_q;
  logic [MAN_W:0]                 mb_q;
  logic [3:0]                     cnt_q;
  logic [15:0]                    result_q;
  logic                           complete_q, busy_q;

  logic                           accept;
  logic [3:0]                     lzc_a, lzc_b;
  logic [MAN_W:0]                 ma_d, mb_d;
  logic signed [7:0]              ea_d, eb_d, e_prep_d;
  logic                           rem_ge;
  logic [QBITS-1:0]               rem_rest, rem_d;
  logic signed [7:0]              dn_amt;
  logic [3:0]                     dn_shift;
  logic [QBITS+DENORM_CAP-1:0]    dn_wide;
  logic                           rnd_inc, rnd_carry;
  logic [QBITS-1:0]               rnd_sum;
  logic signed [7:0]              e_rnd;
  logic [15:0]                    res_d;

  // A new request is also taken in DONE so operations can run back to back
  assign accept   = data_valid && (state_q == IDLE || state_q == DONE);
  assign result   = result_q;
  assign complete = complete_q;
  assign busy     = busy_q;

  fp16_lzc u_lzc_a (.din_i({1'b0, a_q[MAN_W-1:0]}), .count_o(lzc_a));
  fp16_lzc u_lzc_b (.din_i({1'b0, b_q[MAN_W-1:0]}), .count_o(lzc_b));

  // Normalize both operands to 1.xxx; subnormals get exponent 1-lzc
  always_comb begin
    if (a_q[14:MAN_W] != '0) begin
      ma_d = {1'b1, a_q[MAN_W-1:0]};
      ea_d = $signed({3'b000, a_q[14:MAN_W]});
    end else begin
      ma_d = {1'b0, a_q[MAN_W-1:0]} << lzc_a;
      ea_d = 8'sd1 - $signed({4'b0000, lzc_a});
    end
    if (b_q[14:MAN_W] != '0) begin
      mb_d = {1'b1, b_q[MAN_W-1:0]};
      eb_d = $signed({3'b000, b_q[14:MAN_W]});
    end else begin
      mb_d = {1'b0, b_q[MAN_W-1:0]} << lzc_b;
      eb_d = 8'sd1 - $signed({4'b0000, lzc_b});
    end
    e_prep_d = ea_d - eb_d + 8'(BIAS);
  end

  // One restoring step: subtract the divisor when it fits, then shift left
  always_comb begin
    rem_ge   = rem_q >= {1'b0, mb_q};
    rem_rest = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_d    = rem_rest << 1;
  end

  // Right-shift amount for subnormal results, capped so everything lands in sticky
  always_comb begin
    dn_amt   = 8'sd1 - e_q;
    dn_shift = (dn_amt > $signed(8'(DENORM_CAP))) ? 4'(DENORM_CAP) : dn_amt[3:0];
    dn_wide  = {quo_q, {DENORM_CAP{1'b0}}} >> dn_shift;
  end

  // RNE rounding and final result selection; carry into the exponent covers
  // both subnormal-to-normal and 1.111..-to-2.0
  always_comb begin
    rnd_inc   = quo_q[0] & (sticky_q | quo_q[1]);
    rnd_sum   = {1'b0, quo_q[QBITS-1:1]} + {{(QBITS-1){1'b0}}, rnd_inc};
    rnd_carry = (e_q == 8'sd0) ? rnd_sum[MAN_W] : rnd_sum[MAN_W+1];
    e_rnd     = e_q + $signed({7'b0000000, rnd_carry});
    if (b_zero_q) begin
      res_d = {sign_q, MAX_FINITE};
    end else if (a_zero_q) begin
      res_d = {sign_q, 15'h0000};
    end else if (e_q >= 8'sd31 || e_rnd >= 8'sd31) begin
      res_d = {sign_q, MAX_FINITE};
    end else begin
      res_d = {sign_q, e_rnd[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
    end
  end

  // Control FSM and datapath registers; ITER spends one extra cycle to fold
  // the final remainder into sticky, giving the fixed 18-cycle schedule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      a_zero_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      sticky_q   <= 1'b0;
      e_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      mb_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= data1;
            b_q     <= data2;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          sign_q   <= a_q[15] ^ b_q[15];
          a_zero_q <= is_zero(a_q);
          b_zero_q <= is_zero(b_q);
          rem_q    <= {1'b0, ma_d};
          mb_q     <= mb_d;
          e_q      <= e_prep_d;
          quo_q    <= '0;
          sticky_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= ALIGN;
        end
        ALIGN: begin
          if (rem_q < {1'b0, mb_q}) begin
            rem_q <= rem_q << 1;
            e_q   <= e_q - 8'sd1;
          end
          state_q <= ITER;
        end
        ITER: begin
          if (cnt_q == 4'(QBITS)) begin
            sticky_q <= (rem_q != '0);
            state_q  <= DENORM;
          end else begin
            quo_q <= {quo_q[QBITS-2:0], rem_ge};
            rem_q <= rem_d;
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DENORM: begin
          if (e_q <= 8'sd0) begin
            quo_q    <= dn_wide[QBITS+DENORM_CAP-1:DENORM_CAP];
            sticky_q <= sticky_q | (|dn_wide[DENORM_CAP-1:0]);
            e_q      <= '0;
          end
          state_q <= ROUND;
        end
        ROUND: begin
          result_q   <= res_d;
          complete_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          complete_q <= 1'b0;
          if (accept) begin
            a_q     <= data1;
            b_q     <= data2;
            state_q <= PREP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_float16.sv
// Scoreboard bench for div_float16: expected quotients are queued at each
// accept edge and compared when complete is seen.
module tb_div_float16;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data1 = 16'h0000;
  logic [15:0] data2 = 16'h0000;
  logic        data_valid = 1'b0;
  logic [15:0] result;
  logic        complete;
  logic        busy;

  // Hand-derived reference vectors: dividend, divisor, quotient
  logic [15:0] va [NV] = '{16'h4200, 16'h3C00, 16'hBC00, 16'h0000, 16'h3C00, 16'h7BFF, 16'h0400,
                           16'h0001, 16'h0001, 16'h4400, 16'hC500, 16'h7C00, 16'h7BFF, 16'h4000};
  logic [15:0] vb [NV] = '{16'h4000, 16'h4200, 16'h4200, 16'hC000, 16'h0000, 16'h0001, 16'h4000,
                           16'h3800, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h3800, 16'h4000};
  logic [15:0] vr [NV] = '{16'h3E00, 16'h3555, 16'hB555, 16'h8000, 16'h7BFF, 16'h7BFF, 16'h0200,
                           16'h0002, 16'h0000, 16'h4000, 16'hC100, 16'h7800, 16'h7BFF, 16'h3C00};

  int tests_run = 0;
  int tests_failed = 0;

  int          cyc = 0;
  logic [15:0] exp_q [$];
  logic [31:0] ops_q [$];
  int          acc_q [$];
  logic [15:0] exp_v;
  logic [31:0] ops_v;
  int          acc_v;
  logic        prev_cmp = 1'b0;
  logic [15:0] last_res = 16'h0000;
  int          last_done = 0;
  bit          have_prev = 1'b0;
  bit          b2b_mode = 1'b0;

  div_float16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data1      (data1),
    .data2      (data2),
    .data_valid (data_valid),
    .result     (result),
    .complete   (complete),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = 16'hDEAD;
    for (int i = 0; i < NV; i++) begin
      if (va[i] == a && vb[i] == b) r = vr[i];
    end
    return r;
  endfunction

  // Monitor: reset checks, accept capture, output sampling 1ns after each edge
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      check_val("rst_result", result, 16'h0000);
      check_val("rst_complete", complete, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      exp_q.delete();
      ops_q.delete();
      acc_q.delete();
      prev_cmp  = 1'b0;
      last_res  = 16'h0000;
      have_prev = 1'b0;
    end else begin
      cyc++;
      // Accept happens when idle, or in the DONE cycle (complete high)
      if (data_valid && (!busy || complete)) begin
        exp_q.push_back(ref_result(data1, data2));
        ops_q.push_back({data1, data2});
        acc_q.push_back(cyc);
      end
      #1;
      check_val("busy", busy, exp_q.size() != 0);
      if (prev_cmp) check_val("cmp_width", complete, 1'b0);
      if (!b2b_mode) have_prev = 1'b0;
      if (complete) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_complete", 1'b1, 1'b0);
        end else begin
          exp_v = exp_q.pop_front();
          ops_v = ops_q.pop_front();
          acc_v = acc_q.pop_front();
          $display("[TB] txn %04h / %04h -> %04h (want %04h) latency %0d",
                   ops_v[31:16], ops_v[15:0], result, exp_v, cyc - acc_v);
          check_val($sformatf("res %04h/%04h", ops_v[31:16], ops_v[15:0]), result, exp_v);
          // complete is seen after edge E0+17 for an accept at edge E0
          check_val("latency", cyc - acc_v, 17);
          if (b2b_mode) begin
            if (have_prev) check_val("b2b_gap", cyc - last_done, 18);
            have_prev = 1'b1;
          end
          last_done = cyc;
          last_res  = exp_v;
        end
      end else begin
        check_val("result_hold", result, last_res);
      end
      if (acc_q.size() != 0 && (cyc - acc_q[0]) > 17) begin
        check_val("overdue", cyc - acc_q[0], 17);
        void'(exp_q.pop_front());
        void'(ops_q.pop_front());
        void'(acc_q.pop_front());
      end
      prev_cmp = complete;
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    data1      = a;
    data2      = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int idx;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op(va[i], vb[i]);

    // Leave a nonzero result, then abort an operation while it iterates
    run_op(16'h3C00, 16'h4200);
    @(negedge clk);
    data1      = 16'h4200;
    data2      = 16'h4000;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    run_op(16'h4400, 16'h4000);

    // data_valid held high with operands changing every cycle
    b2b_mode = 1'b1;
    @(negedge clk);
    data_valid = 1'b1;
    for (int k = 0; k < 90; k++) begin
      idx   = $urandom_range(0, NV - 1);
      data1 = va[idx];
      data2 = vb[idx];
      @(negedge clk);
    end
    data_valid = 1'b0;
    wait_idle();
    b2b_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
